// File: rtl/decoder2x4_scan.sv
// decoder2x4_scan: registered 2-to-4 one-hot decoder with an auto-scan
// sequencer that rotates the select with a programmable dwell per position.
module decoder2x4_scan #(
   parameter int unsigned DWELL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       clr,
   input  logic       load,
   input  logic       scan,
   input  logic [1:0] din,
   output logic [3:0] qout,
   output logic [1:0] idx,
   output logic       active,
   output logic       chg,
   output logic       wrap
);

   localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      SCAN = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic [1:0]    idx_nxt;
   logic [3:0]    qout_nxt;
   logic          chg_nxt;
   logic          wrap_nxt;
   logic          step;

   // State register; reset returns to IDLE immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state: command priority clr > load > scan, all gated by en.
   always_comb begin
      state_nxt = state;
      if (en) begin
         case (state)
            IDLE: begin
               if (clr)       state_nxt = IDLE;
               else if (load) state_nxt = HOLD;
               else if (scan) state_nxt = SCAN;
            end
            HOLD: begin
               if (clr)       state_nxt = IDLE;
               else if (load) state_nxt = HOLD;
               else if (scan) state_nxt = SCAN;
            end
            SCAN: begin
               if (clr)        state_nxt = IDLE;
               else if (load)  state_nxt = HOLD;
               else if (!scan) state_nxt = HOLD;
               else            state_nxt = SCAN;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Next index/dwell count and the pulses derived from the next select.
   always_comb begin
      idx_nxt = idx;
      cnt_nxt = cnt;
      step    = 1'b0;
      if (en) begin
         case (state)
            IDLE: begin
               if (!clr && (load || scan)) begin
                  idx_nxt = din;
                  cnt_nxt = '0;
               end
            end
            HOLD: begin
               if (clr) begin
                  idx_nxt = 2'b00;
                  cnt_nxt = '0;
               end else if (load) begin
                  idx_nxt = din;
               end else if (scan) begin
                  cnt_nxt = '0;
               end
            end
            SCAN: begin
               if (clr) begin
                  idx_nxt = 2'b00;
                  cnt_nxt = '0;
               end else if (load) begin
                  idx_nxt = din;
                  cnt_nxt = '0;
               end else if (!scan) begin
                  cnt_nxt = '0;
               end else if (cnt == CNT_LAST) begin
                  step    = 1'b1;
                  idx_nxt = idx + 2'd1;
                  cnt_nxt = '0;
               end else begin
                  cnt_nxt = cnt + CW'(1);
               end
            end
            default: begin
               idx_nxt = 2'b00;
               cnt_nxt = '0;
            end
         endcase
      end
      qout_nxt = (state_nxt == IDLE) ? 4'b0000 : (4'b0001 << idx_nxt);
      chg_nxt  = en && (qout_nxt != qout);
      wrap_nxt = step && (idx == 2'b11);
   end

   // Datapath and output registers; reset produces no chg/wrap pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx    <= 2'b00;
         cnt    <= '0;
         qout   <= 4'b0000;
         active <= 1'b0;
         chg    <= 1'b0;
         wrap   <= 1'b0;
      end else begin
         idx    <= idx_nxt;
         cnt    <= cnt_nxt;
         qout   <= qout_nxt;
         active <= (state_nxt != IDLE);
         chg    <= chg_nxt;
         wrap   <= wrap_nxt;
      end
   end

endmodule

// File: tb/tb_decoder2x4_scan.sv
// Directed bench for decoder2x4_scan: one DUT with DWELL=4, one with DWELL=1.
module tb_decoder2x4_scan;

   logic       clk;
   logic       rst, en, clr, load, scan;
   logic [1:0] din;
   logic [3:0] qout;
   logic [1:0] idx;
   logic       active, chg, wrap;

   logic       r1, e1, c1, l1, s1;
   logic [1:0] d1;
   logic [3:0] q1;
   logic [1:0] i1;
   logic       a1, ch1, w1;

   int total = 0;
   int bad   = 0;

   decoder2x4_scan #(.DWELL(4)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .load(load), .scan(scan),
      .din(din), .qout(qout), .idx(idx), .active(active), .chg(chg), .wrap(wrap)
   );

   decoder2x4_scan #(.DWELL(1)) dut1 (
      .clk(clk), .rst(r1), .en(e1), .clr(c1), .load(l1), .scan(s1),
      .din(d1), .qout(q1), .idx(i1), .active(a1), .chg(ch1), .wrap(w1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Reset state after the power-on reset pulse.
      total++;
      if (qout !== 4'b0000 || idx !== 2'b00 || active !== 1'b0 || chg !== 1'b0 || wrap !== 1'b0) begin
         bad++;
         $display("FAIL reset_init: qout=%b idx=%b active=%b chg=%b wrap=%b want 0000/00/0/0/0", qout, idx, active, chg, wrap);
      end
      din = 2'b10; load = 1'b1; tick(); load = 1'b0;
      total++;
      if (qout !== 4'b0100) begin
         bad++;
         $display("FAIL reset_preload: qout=%b want 0100", qout);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if (qout !== 4'b0000 || idx !== 2'b00 || active !== 1'b0 || chg !== 1'b0) begin
         bad++;
         $display("FAIL reset_async: qout=%b idx=%b active=%b chg=%b want 0000/00/0/0", qout, idx, active, chg);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if (chg !== 1'b0 || wrap !== 1'b0 || qout !== 4'b0000) begin
            bad++;
            $display("FAIL reset_hold%0d: chg=%b wrap=%b qout=%b want 0/0/0000", k, chg, wrap, qout);
         end
      end
      #2 rst = 1'b0;
   endtask

   task automatic test_static_decode();
      logic [3:0] exp_q [4];
      exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      load = 1'b1;
      for (int i = 0; i < 4; i++) begin
         din = 2'(i);
         tick();
         total++;
         if (qout !== exp_q[i] || idx !== 2'(i) || chg !== 1'b1 || active !== 1'b1) begin
            bad++;
            $display("FAIL static_%0d: qout=%b idx=%b chg=%b active=%b want %b/%0d/1/1", i, qout, idx, chg, active, exp_q[i], i);
         end
      end
      // Reloading the same code does not change qout.
      din = 2'b11; tick();
      total++;
      if (qout !== 4'b1000 || chg !== 1'b0) begin
         bad++;
         $display("FAIL static_same: qout=%b chg=%b want 1000/0", qout, chg);
      end
      // Load of 00 from 11 is not a scan wrap.
      din = 2'b00; tick();
      total++;
      if (qout !== 4'b0001 || chg !== 1'b1 || wrap !== 1'b0) begin
         bad++;
         $display("FAIL static_load_wrap: qout=%b chg=%b wrap=%b want 0001/1/0", qout, chg, wrap);
      end
      load = 1'b0;
   endtask

   task automatic test_scan();
      logic [3:0] pos_q [4];
      logic [3:0] eq;
      logic       ec, ew;
      pos_q = '{4'b0100, 4'b1000, 4'b0001, 4'b0010};
      clr = 1'b1; tick(); clr = 1'b0;
      total++;
      if (qout !== 4'b0000 || chg !== 1'b1 || active !== 1'b0) begin
         bad++;
         $display("FAIL scan_clr: qout=%b chg=%b active=%b want 0000/1/0", qout, chg, active);
      end
      din = 2'b10; scan = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         tick();
         eq = pos_q[(k - 1) / 4];
         ec = ((k - 1) % 4) == 0;
         ew = (k == 9);
         total++;
         if (qout !== eq || chg !== ec || wrap !== ew) begin
            bad++;
            $display("FAIL scan_cyc%0d: qout=%b chg=%b wrap=%b want %b/%b/%b", k, qout, chg, wrap, eq, ec, ew);
         end
      end
      // Dropping scan parks in HOLD at the current position.
      scan = 1'b0; tick();
      total++;
      if (qout !== 4'b0010 || idx !== 2'b01 || chg !== 1'b0 || active !== 1'b1) begin
         bad++;
         $display("FAIL scan_park: qout=%b idx=%b chg=%b active=%b want 0010/01/0/1", qout, idx, chg, active);
      end
   endtask

   task automatic test_priority();
      din = 2'b11; load = 1'b1; tick(); load = 1'b0;
      scan = 1'b1; tick();
      total++;
      if (qout !== 4'b1000 || idx !== 2'b11) begin
         bad++;
         $display("FAIL prio_setup: qout=%b idx=%b want 1000/11", qout, idx);
      end
      clr = 1'b1; load = 1'b1; din = 2'b01; tick();
      clr = 1'b0; load = 1'b0; scan = 1'b0;
      total++;
      if (qout !== 4'b0000 || idx !== 2'b00 || active !== 1'b0 || chg !== 1'b1 || wrap !== 1'b0) begin
         bad++;
         $display("FAIL prio_clr_load: qout=%b idx=%b active=%b chg=%b wrap=%b want 0000/00/0/1/0", qout, idx, active, chg, wrap);
      end
   endtask

   task automatic test_freeze();
      // Enter scan at idx 00, then two enabled steps of the dwell counter.
      din = 2'b00; scan = 1'b1; tick();
      tick(); tick();
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if (qout !== 4'b0001 || idx !== 2'b00 || chg !== 1'b0 || wrap !== 1'b0) begin
            bad++;
            $display("FAIL freeze_%0d: qout=%b idx=%b chg=%b wrap=%b want 0001/00/0/0", k, qout, idx, chg, wrap);
         end
      end
      // Position has used 3 of its 4 enabled cycles: one more hold, then step.
      en = 1'b1; tick();
      total++;
      if (qout !== 4'b0001 || chg !== 1'b0) begin
         bad++;
         $display("FAIL freeze_resume_hold: qout=%b chg=%b want 0001/0", qout, chg);
      end
      tick();
      total++;
      if (qout !== 4'b0010 || idx !== 2'b01 || chg !== 1'b1) begin
         bad++;
         $display("FAIL freeze_resume_step: qout=%b idx=%b chg=%b want 0010/01/1", qout, idx, chg);
      end
      scan = 1'b0; tick();
   endtask

   task automatic test_reset_dwell1();
      logic [3:0] seq [5];
      seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      d1 = 2'b00; e1 = 1'b1; s1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         total++;
         if (q1 !== seq[k] || ch1 !== 1'b1 || w1 !== (k == 4)) begin
            bad++;
            $display("FAIL d1_seq%0d: qout=%b chg=%b wrap=%b want %b/1/%b", k, q1, ch1, w1, seq[k], (k == 4));
         end
      end
      tick();
      #2 r1 = 1'b1;
      #1;
      total++;
      if (q1 !== 4'b0000 || a1 !== 1'b0 || ch1 !== 1'b0 || w1 !== 1'b0) begin
         bad++;
         $display("FAIL d1_rst_async: qout=%b active=%b chg=%b wrap=%b want 0000/0/0/0", q1, a1, ch1, w1);
      end
      e1 = 1'b0; d1 = 2'b10;
      tick();
      #2 r1 = 1'b0;
      for (int k = 0; k < 2; k++) begin
         tick();
         total++;
         if (q1 !== 4'b0000 || a1 !== 1'b0 || ch1 !== 1'b0) begin
            bad++;
            $display("FAIL d1_idle%0d: qout=%b active=%b chg=%b want 0000/0/0", k, q1, a1, ch1);
         end
      end
      e1 = 1'b1; tick();
      total++;
      if (q1 !== 4'b0100 || i1 !== 2'b10 || a1 !== 1'b1 || ch1 !== 1'b1) begin
         bad++;
         $display("FAIL d1_rescan: qout=%b idx=%b active=%b chg=%b want 0100/10/1/1", q1, i1, a1, ch1);
      end
      s1 = 1'b0; e1 = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; clr = 1'b0; load = 1'b0; scan = 1'b0; din = 2'b00;
      r1  = 1'b1; e1 = 1'b0; c1 = 1'b0;  l1 = 1'b0;   s1 = 1'b0;   d1 = 2'b00;
      tick();
      #2 rst = 1'b0; r1 = 1'b0;
      tick();
      test_reset();
      test_static_decode();
      test_scan();
      test_priority();
      test_freeze();
      test_reset_dwell1();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
